// File: rtl/issue_pkg.sv
// issue_pkg: decoded-instruction bundle, load shadow
// and hazard/bypass helpers for the dual-issue queue.
package issue_pkg;

  localparam logic [5:0] WB_SEL_LOAD = 6'b000010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        rf_re1;
    logic        rf_re2;
    logic [2:0]  alu_src_sel1;
    logic [2:0]  alu_src_sel2;
    logic [11:0] alu_op;
    logic [3:0]  br_type;
    logic        br_pd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic        is_load;
    logic [5:0]  wb_mux_select;
  } decoded_inst_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } ld_shadow_t;

  function automatic logic is_ld(
    input decoded_inst_t i
  );
    return i.is_load ||
      (i.wb_mux_select == WB_SEL_LOAD);
  endfunction

  function automatic logic is_mem(
    input decoded_inst_t i
  );
    return i.mem_we || is_ld(i);
  endfunction

  // r0 is never a real dependency
  function automatic logic reads_reg(
    input decoded_inst_t i,
    input logic [4:0]    r
  );
    return (r != 5'd0) &&
      ((i.rf_re1 && i.rf_raddr1 == r) ||
       (i.rf_re2 && i.rf_raddr2 == r));
  endfunction

  function automatic logic [31:0] bypass(
    input logic [4:0]  ra,
    input logic [31:0] rd,
    input logic        we_a,
    input logic [4:0]  wa_a,
    input logic [31:0] wd_a,
    input logic        we_b,
    input logic [4:0]  wa_b,
    input logic [31:0] wd_b
  );
    if (ra == 5'd0) return rd;
    if (we_b && wa_b == ra) return wd_b;
    if (we_a && wa_a == ra) return wd_a;
    return rd;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: 2-push/2-pop circular buffer exposing
// the two oldest entries to the issue selector.
module issue_fifo
  import issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic [1:0]              push_n,
  input  logic [1:0]              pop_n,
  input  decoded_inst_t           push0,
  input  decoded_inst_t           push1,
  output decoded_inst_t           h0,
  output decoded_inst_t           h1,
  output logic                    h0_v,
  output logic                    h1_v,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  decoded_inst_t  mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;

  assign h0   = mem[head];
  assign h1   = mem[head + AW'(1)];
  assign h0_v = count != '0;
  assign h1_v = count > CW'(1);

  // pop is applied before push; pointers wrap naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count - CW'(pop_n)
             + CW'(push_n);
      if (push_n != 2'd0)
        mem[tail] <= push0;
      if (push_n == 2'd2)
        mem[tail + AW'(1)] <= push1;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: dual-issue selector with load-use
// tracking, WB bypass and registered EX bundle.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    in_valid,
  input  decoded_inst_t in_inst0,
  input  decoded_inst_t in_inst1,
  output logic          in_ready,
  output logic [4:0]    rf_raddr_a1,
  output logic [4:0]    rf_raddr_a2,
  output logic [4:0]    rf_raddr_b1,
  output logic [4:0]    rf_raddr_b2,
  input  logic [31:0]   rf_rdata_a1,
  input  logic [31:0]   rf_rdata_a2,
  input  logic [31:0]   rf_rdata_b1,
  input  logic [31:0]   rf_rdata_b2,
  input  logic          WB_rf_we_a,
  input  logic          WB_rf_we_b,
  input  logic [4:0]    WB_rf_waddr_a,
  input  logic [4:0]    WB_rf_waddr_b,
  input  logic [31:0]   WB_rf_wdata_a,
  input  logic [31:0]   WB_rf_wdata_b,
  input  logic          EX_br,
  input  logic          stall_dcache,
  output logic          EX_valid_a,
  output logic          EX_valid_b,
  output decoded_inst_t EX_inst_a,
  output decoded_inst_t EX_inst_b,
  output logic [31:0]   EX_rf_rdata_a1,
  output logic [31:0]   EX_rf_rdata_a2,
  output logic [31:0]   EX_rf_rdata_b1,
  output logic [31:0]   EX_rf_rdata_b2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]  count;
  decoded_inst_t  h0, h1;
  logic           h0_v, h1_v;
  logic [1:0]     push_n, pop_n, pop_sel;
  ld_shadow_t     ex_ld, mem_ld;
  decoded_inst_t  sel_a, sel_b;
  logic           iss_a, iss_b;
  logic           h0_blk, h1_blk;
  logic           h0_mem, pair_ok;
  logic [31:0]    op_a1, op_a2, op_b1, op_b2;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .flush  (EX_br),
    .push_n (push_n),
    .pop_n  (pop_n),
    .push0  (in_inst0),
    .push1  (in_inst1),
    .h0     (h0),
    .h1     (h1),
    .h0_v   (h0_v),
    .h1_v   (h1_v),
    .count  (count)
  );

  assign in_ready = !stall_dcache &&
    (count <= CW'(DEPTH - 2));

  assign push_n = (EX_br || !in_ready) ? 2'd0 :
    (in_valid == 2'b11) ? 2'd2 :
    (in_valid == 2'b01) ? 2'd1 : 2'd0;

  assign pop_n = (EX_br || stall_dcache) ?
    2'd0 : pop_sel;

  assign h0_blk =
    (ex_ld.v  && reads_reg(h0, ex_ld.rd)) ||
    (mem_ld.v && reads_reg(h0, mem_ld.rd));
  assign h1_blk =
    (ex_ld.v  && reads_reg(h1, ex_ld.rd)) ||
    (mem_ld.v && reads_reg(h1, mem_ld.rd));

  assign h0_mem  = is_mem(h0);
  assign pair_ok = h1_v && !h0_mem &&
    (h0.br_type == 4'd0) && !h1_blk &&
    !(h0.rf_we && reads_reg(h1, h0.rf_waddr));

  always_comb begin
    iss_a   = 1'b0;
    iss_b   = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    pop_sel = 2'd0;
    if (h0_v && !h0_blk) begin
      unique case (1'b1)
        h0_mem: begin
          iss_b   = 1'b1;
          sel_b   = h0;
          pop_sel = 2'd1;
        end
        pair_ok: begin
          iss_a   = 1'b1;
          iss_b   = 1'b1;
          sel_a   = h0;
          sel_b   = h1;
          pop_sel = 2'd2;
        end
        default: begin
          iss_a   = 1'b1;
          sel_a   = h0;
          pop_sel = 2'd1;
        end
      endcase
    end
  end

  assign rf_raddr_a1 = sel_a.rf_raddr1;
  assign rf_raddr_a2 = sel_a.rf_raddr2;
  assign rf_raddr_b1 = sel_b.rf_raddr1;
  assign rf_raddr_b2 = sel_b.rf_raddr2;

  assign op_a1 = bypass(rf_raddr_a1, rf_rdata_a1,
    WB_rf_we_a, WB_rf_waddr_a, WB_rf_wdata_a,
    WB_rf_we_b, WB_rf_waddr_b, WB_rf_wdata_b);
  assign op_a2 = bypass(rf_raddr_a2, rf_rdata_a2,
    WB_rf_we_a, WB_rf_waddr_a, WB_rf_wdata_a,
    WB_rf_we_b, WB_rf_waddr_b, WB_rf_wdata_b);
  assign op_b1 = bypass(rf_raddr_b1, rf_rdata_b1,
    WB_rf_we_a, WB_rf_waddr_a, WB_rf_wdata_a,
    WB_rf_we_b, WB_rf_waddr_b, WB_rf_wdata_b);
  assign op_b2 = bypass(rf_raddr_b2, rf_rdata_b2,
    WB_rf_we_a, WB_rf_waddr_a, WB_rf_wdata_a,
    WB_rf_we_b, WB_rf_waddr_b, WB_rf_wdata_b);

  // loads only ever issue in slot B
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      EX_valid_a     <= 1'b0;
      EX_valid_b     <= 1'b0;
      EX_inst_a      <= '0;
      EX_inst_b      <= '0;
      EX_rf_rdata_a1 <= '0;
      EX_rf_rdata_a2 <= '0;
      EX_rf_rdata_b1 <= '0;
      EX_rf_rdata_b2 <= '0;
      ex_ld          <= '0;
      mem_ld         <= '0;
    end else if (EX_br) begin
      EX_valid_a     <= 1'b0;
      EX_valid_b     <= 1'b0;
      EX_inst_a      <= '0;
      EX_inst_b      <= '0;
      EX_rf_rdata_a1 <= '0;
      EX_rf_rdata_a2 <= '0;
      EX_rf_rdata_b1 <= '0;
      EX_rf_rdata_b2 <= '0;
      ex_ld          <= '0;
      mem_ld         <= ex_ld;
    end else if (!stall_dcache) begin
      EX_valid_a     <= iss_a;
      EX_valid_b     <= iss_b;
      EX_inst_a      <= sel_a;
      EX_inst_b      <= sel_b;
      EX_rf_rdata_a1 <= iss_a ? op_a1 : '0;
      EX_rf_rdata_a2 <= iss_a ? op_a2 : '0;
      EX_rf_rdata_b1 <= iss_b ? op_b1 : '0;
      EX_rf_rdata_b2 <= iss_b ? op_b2 : '0;
      ex_ld <= '{v:  iss_b && is_ld(sel_b),
                 rd: sel_b.rf_waddr};
      mem_ld <= ex_ld;
    end
  end

  a_no_hi_only: assert property (
    @(posedge clk) disable iff (!rstn)
    in_valid != 2'b10);

  a_no_overrun: assert property (
    @(posedge clk) disable iff (!rstn)
    !(in_valid != 2'b00 && !in_ready &&
      !stall_dcache && !EX_br));

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: vector table for issue/hazard/bypass
// plus flush, stall, wrap and reset sequences.
module tb_issue_queue;
  import issue_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    in_valid = '0;
  decoded_inst_t in_inst0 = '0;
  decoded_inst_t in_inst1 = '0;
  logic          in_ready;
  logic [4:0]    rf_raddr_a1, rf_raddr_a2;
  logic [4:0]    rf_raddr_b1, rf_raddr_b2;
  logic [31:0]   rf_rdata_a1, rf_rdata_a2;
  logic [31:0]   rf_rdata_b1, rf_rdata_b2;
  logic          wb_we_a = 1'b0, wb_we_b = 1'b0;
  logic [4:0]    wb_wa_a = '0, wb_wa_b = '0;
  logic [31:0]   wb_wd_a = '0, wb_wd_b = '0;
  logic          EX_br = 1'b0;
  logic          stall_dcache = 1'b0;
  logic          EX_valid_a, EX_valid_b;
  decoded_inst_t EX_inst_a, EX_inst_b;
  logic [31:0]   EX_rf_rdata_a1, EX_rf_rdata_a2;
  logic [31:0]   EX_rf_rdata_b1, EX_rf_rdata_b2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_inst0       (in_inst0),
    .in_inst1       (in_inst1),
    .in_ready       (in_ready),
    .rf_raddr_a1    (rf_raddr_a1),
    .rf_raddr_a2    (rf_raddr_a2),
    .rf_raddr_b1    (rf_raddr_b1),
    .rf_raddr_b2    (rf_raddr_b2),
    .rf_rdata_a1    (rf_rdata_a1),
    .rf_rdata_a2    (rf_rdata_a2),
    .rf_rdata_b1    (rf_rdata_b1),
    .rf_rdata_b2    (rf_rdata_b2),
    .WB_rf_we_a     (wb_we_a),
    .WB_rf_we_b     (wb_we_b),
    .WB_rf_waddr_a  (wb_wa_a),
    .WB_rf_waddr_b  (wb_wa_b),
    .WB_rf_wdata_a  (wb_wd_a),
    .WB_rf_wdata_b  (wb_wd_b),
    .EX_br          (EX_br),
    .stall_dcache   (stall_dcache),
    .EX_valid_a     (EX_valid_a),
    .EX_valid_b     (EX_valid_b),
    .EX_inst_a      (EX_inst_a),
    .EX_inst_b      (EX_inst_b),
    .EX_rf_rdata_a1 (EX_rf_rdata_a1),
    .EX_rf_rdata_a2 (EX_rf_rdata_a2),
    .EX_rf_rdata_b1 (EX_rf_rdata_b1),
    .EX_rf_rdata_b2 (EX_rf_rdata_b2)
  );

  function automatic logic [31:0] rf_val(
    input logic [4:0] a
  );
    case (a)
      5'd2:    return 32'd10;
      5'd3:    return 32'd20;
      5'd5:    return 32'd30;
      5'd6:    return 32'd40;
      default: return 32'(a) * 32'd1000;
    endcase
  endfunction

  assign rf_rdata_a1 = rf_val(rf_raddr_a1);
  assign rf_rdata_a2 = rf_val(rf_raddr_a2);
  assign rf_rdata_b1 = rf_val(rf_raddr_b1);
  assign rf_rdata_b2 = rf_val(rf_raddr_b2);

  function automatic decoded_inst_t alu(
    input logic [31:0] pc,
    input logic [4:0]  rd, rs1, rs2
  );
    decoded_inst_t i;
    i = '0;
    i.pc = pc;
    i.imm = pc ^ 32'h5a5a;
    i.rf_raddr1 = rs1;
    i.rf_raddr2 = rs2;
    i.rf_re1 = 1'b1;
    i.rf_re2 = 1'b1;
    i.alu_op = 12'h001;
    i.rf_we = 1'b1;
    i.rf_waddr = rd;
    return i;
  endfunction

  function automatic decoded_inst_t ldw(
    input logic [31:0] pc,
    input logic [4:0]  rd, rs1
  );
    decoded_inst_t i;
    i = alu(pc, rd, rs1, 5'd0);
    i.rf_re2 = 1'b0;
    i.is_load = 1'b1;
    i.mem_type = 3'd2;
    i.wb_mux_select = WB_SEL_LOAD;
    return i;
  endfunction

  function automatic decoded_inst_t stw(
    input logic [31:0] pc,
    input logic [4:0]  rs1, rs2
  );
    decoded_inst_t i;
    i = alu(pc, 5'd0, rs1, rs2);
    i.rf_we = 1'b0;
    i.mem_we = 1'b1;
    i.mem_type = 3'd2;
    return i;
  endfunction

  function automatic decoded_inst_t beq(
    input logic [31:0] pc,
    input logic [4:0]  rs1, rs2
  );
    decoded_inst_t i;
    i = alu(pc, 5'd0, rs1, rs2);
    i.rf_we = 1'b0;
    i.br_type = 4'd1;
    return i;
  endfunction

  typedef struct {
    logic [1:0]    v;
    decoded_inst_t i0, i1;
    logic          wa_we, wb_we;
    logic [4:0]    wa_ad, wb_ad;
    logic [31:0]   wa_d, wb_d;
    logic [1:0]    ev;
    logic [31:0]   pa, pb, a1, a2, b1, b2;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t ex(
    input logic [1:0]  ev,
    input logic [31:0] pa, pb,
    input logic [31:0] a1, a2, b1, b2
  );
    vec_t t;
    t.v = 2'b00; t.i0 = '0; t.i1 = '0;
    t.wa_we = 1'b0; t.wa_ad = '0; t.wa_d = '0;
    t.wb_we = 1'b0; t.wb_ad = '0; t.wb_d = '0;
    t.ev = ev; t.pa = pa; t.pb = pb;
    t.a1 = a1; t.a2 = a2; t.b1 = b1; t.b2 = b2;
    return t;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
        nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic [1:0]    v,
    input decoded_inst_t a,
    input decoded_inst_t b
  );
    in_valid = v;
    in_inst0 = a;
    in_inst1 = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    EX_br    = 1'b0;
    wb_we_a  = 1'b0;
    wb_we_b  = 1'b0;
  endtask

  function automatic logic [31:0] exv();
    return {30'd0, EX_valid_b, EX_valid_a};
  endfunction

  task automatic build_table();
    vec_t t;
    // independent pair
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = alu(32'h100, 5'd1, 5'd2, 5'd3);
    t.i1 = alu(32'h104, 5'd4, 5'd5, 5'd6);
    vt.push_back(t);
    vt.push_back(ex(2'b11, 32'h100, 32'h104,
      10, 20, 30, 40));
    // RAW inside the pair
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = alu(32'h108, 5'd1, 5'd2, 5'd3);
    t.i1 = alu(32'h10c, 5'd7, 5'd1, 5'd2);
    vt.push_back(t);
    vt.push_back(ex(2'b01, 32'h108, 0,
      10, 20, 0, 0));
    vt.push_back(ex(2'b01, 32'h10c, 0,
      1000, 10, 0, 0));
    // load-use, data arrives by WB bypass
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = ldw(32'h110, 5'd5, 5'd2);
    t.i1 = alu(32'h114, 5'd6, 5'd5, 5'd5);
    vt.push_back(t);
    vt.push_back(ex(2'b10, 0, 32'h110,
      0, 0, 10, 0));
    vt.push_back(ex(2'b00, 0, 0, 0, 0, 0, 0));
    vt.push_back(ex(2'b00, 0, 0, 0, 0, 0, 0));
    t = ex(2'b01, 32'h114, 0,
      32'hdeadbeef, 32'hdeadbeef, 0, 0);
    t.wb_we = 1'b1; t.wb_ad = 5'd5;
    t.wb_d = 32'hdeadbeef;
    vt.push_back(t);
    // bypass on both ports
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = alu(32'h118, 5'd8, 5'd2, 5'd3);
    t.i1 = alu(32'h11c, 5'd9, 5'd5, 5'd6);
    vt.push_back(t);
    t = ex(2'b11, 32'h118, 32'h11c,
      32'hbbbb0002, 20, 32'haaaa0005, 40);
    t.wa_we = 1'b1; t.wa_ad = 5'd5;
    t.wa_d = 32'haaaa0005;
    t.wb_we = 1'b1; t.wb_ad = 5'd2;
    t.wb_d = 32'hbbbb0002;
    vt.push_back(t);
    // same address on both ports: B wins
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b01;
    t.i0 = alu(32'h120, 5'd10, 5'd0, 5'd3);
    vt.push_back(t);
    t = ex(2'b01, 32'h120, 0,
      0, 32'hb3, 0, 0);
    t.wa_we = 1'b1; t.wa_ad = 5'd3;
    t.wa_d = 32'ha3;
    t.wb_we = 1'b1; t.wb_ad = 5'd3;
    t.wb_d = 32'hb3;
    vt.push_back(t);
    // r0 never bypassed
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b01;
    t.i0 = alu(32'h124, 5'd11, 5'd0, 5'd0);
    vt.push_back(t);
    t = ex(2'b01, 32'h124, 0, 0, 0, 0, 0);
    t.wa_we = 1'b1; t.wa_ad = 5'd0;
    t.wa_d = 32'h1234;
    t.wb_we = 1'b1; t.wb_ad = 5'd0;
    t.wb_d = 32'h5678;
    vt.push_back(t);
    // branch at H0 issues alone
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = beq(32'h128, 5'd2, 5'd3);
    t.i1 = alu(32'h12c, 5'd12, 5'd2, 5'd3);
    vt.push_back(t);
    vt.push_back(ex(2'b01, 32'h128, 0,
      10, 20, 0, 0));
    vt.push_back(ex(2'b01, 32'h12c, 0,
      10, 20, 0, 0));
    // store as H1 pairs into slot B
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = alu(32'h130, 5'd13, 5'd2, 5'd3);
    t.i1 = stw(32'h134, 5'd2, 5'd3);
    vt.push_back(t);
    vt.push_back(ex(2'b11, 32'h130, 32'h134,
      10, 20, 10, 20));
    // store as H0 issues alone in slot B
    t = ex(2'b00, 0, 0, 0, 0, 0, 0);
    t.v = 2'b11;
    t.i0 = stw(32'h138, 5'd2, 5'd3);
    t.i1 = alu(32'h13c, 5'd14, 5'd5, 5'd6);
    vt.push_back(t);
    vt.push_back(ex(2'b10, 0, 32'h138,
      0, 0, 10, 20));
    vt.push_back(ex(2'b01, 32'h13c, 0,
      30, 40, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    decoded_inst_t sb[$];
    decoded_inst_t want;
    int sent, got;

    #2;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", exv(), 0);
    chk("rst_inst_a", 32'(EX_inst_a == '0), 1);
    chk("rst_inst_b", 32'(EX_inst_b == '0), 1);
    chk("rst_rd_a1", EX_rf_rdata_a1, 0);
    chk("rst_rd_b2", EX_rf_rdata_b2, 0);
    @(negedge clk);
    rstn = 1'b1;

    build_table();
    foreach (vt[k]) begin
      drive(vt[k].v, vt[k].i0, vt[k].i1);
      wb_we_a = vt[k].wa_we;
      wb_wa_a = vt[k].wa_ad;
      wb_wd_a = vt[k].wa_d;
      wb_we_b = vt[k].wb_we;
      wb_wa_b = vt[k].wb_ad;
      wb_wd_b = vt[k].wb_d;
      step();
      chk($sformatf("v%0d_valid", k),
        exv(), 32'(vt[k].ev));
      chk($sformatf("v%0d_pc_a", k),
        EX_inst_a.pc, vt[k].pa);
      chk($sformatf("v%0d_pc_b", k),
        EX_inst_b.pc, vt[k].pb);
      chk($sformatf("v%0d_a1", k),
        EX_rf_rdata_a1, vt[k].a1);
      chk($sformatf("v%0d_a2", k),
        EX_rf_rdata_a2, vt[k].a2);
      chk($sformatf("v%0d_b1", k),
        EX_rf_rdata_b1, vt[k].b1);
      chk($sformatf("v%0d_b2", k),
        EX_rf_rdata_b2, vt[k].b2);
    end

    // flush with 5 queued entries and a push
    drive(2'b11, ldw(32'h400, 5'd20, 5'd2),
      alu(32'h404, 5'd21, 5'd20, 5'd20));
    step();
    chk("fl_e0", exv(), 0);
    drive(2'b11, alu(32'h408, 5'd22, 5'd20, 5'd1),
      alu(32'h40c, 5'd23, 5'd2, 5'd3));
    step();
    chk("fl_ld_v", exv(), 2);
    chk("fl_ld_pc", EX_inst_b.pc, 32'h400);
    drive(2'b11, alu(32'h410, 5'd24, 5'd2, 5'd3),
      alu(32'h414, 5'd25, 5'd2, 5'd3));
    step();
    chk("fl_blk_v", exv(), 0);
    chk("fl_5_ready", 32'(in_ready), 1);
    drive(2'b11, alu(32'h418, 5'd26, 5'd2, 5'd3),
      alu(32'h41c, 5'd27, 5'd2, 5'd3));
    EX_br = 1'b1;
    step();
    chk("fl_v", exv(), 0);
    chk("fl_ready", 32'(in_ready), 1);
    step();
    chk("fl_empty_v", exv(), 0);
    drive(2'b01, alu(32'h420, 5'd28, 5'd2, 5'd3),
      '0);
    step();
    chk("fl_new0_v", exv(), 0);
    step();
    chk("fl_new_v", exv(), 1);
    chk("fl_new_pc", EX_inst_a.pc, 32'h420);

    // stall holds EX and queue
    drive(2'b11, alu(32'h500, 5'd10, 5'd2, 5'd3),
      alu(32'h504, 5'd11, 5'd5, 5'd6));
    step();
    drive(2'b11, alu(32'h508, 5'd12, 5'd2, 5'd3),
      alu(32'h50c, 5'd13, 5'd5, 5'd6));
    step();
    chk("st_pre_v", exv(), 3);
    chk("st_pre_pc", EX_inst_a.pc, 32'h500);
    stall_dcache = 1'b1;
    #1;
    chk("st_ready_now", 32'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("st%0d_v", c), exv(), 3);
      chk($sformatf("st%0d_pa", c),
        EX_inst_a.pc, 32'h500);
      chk($sformatf("st%0d_pb", c),
        EX_inst_b.pc, 32'h504);
      chk($sformatf("st%0d_a1", c),
        EX_rf_rdata_a1, 10);
      chk($sformatf("st%0d_rdy", c),
        32'(in_ready), 0);
    end
    stall_dcache = 1'b0;
    step();
    chk("st_post_v", exv(), 3);
    chk("st_post_pa", EX_inst_a.pc, 32'h508);
    chk("st_post_pb", EX_inst_b.pc, 32'h50c);

    // 20 pushes streaming across pointer wrap
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 20; c++) begin
      if (sent < 20 && in_ready) begin
        drive(2'b11,
          alu(32'h300 + 32'(sent) * 4,
            5'(10 + sent), 5'd2, 5'd3),
          alu(32'h304 + 32'(sent) * 4,
            5'(11 + sent), 5'd5, 5'd6));
        sb.push_back(in_inst0);
        sb.push_back(in_inst1);
        sent += 2;
      end
      step();
      if (EX_valid_a) begin
        want = (sb.size() != 0) ?
          sb.pop_front() : '0;
        chk($sformatf("wr%0d_a_pc", got),
          EX_inst_a.pc, want.pc);
        chk($sformatf("wr%0d_a_inst", got),
          32'(EX_inst_a == want), 1);
        got++;
      end
      if (EX_valid_b) begin
        want = (sb.size() != 0) ?
          sb.pop_front() : '0;
        chk($sformatf("wr%0d_b_pc", got),
          EX_inst_b.pc, want.pc);
        chk($sformatf("wr%0d_b_op", got),
          EX_rf_rdata_b1, 30);
        got++;
      end
    end
    chk("wr_count", got, 20);

    // asynchronous reset mid-stream
    drive(2'b11, alu(32'h600, 5'd10, 5'd2, 5'd3),
      alu(32'h604, 5'd11, 5'd5, 5'd6));
    step();
    drive(2'b11, alu(32'h608, 5'd12, 5'd2, 5'd3),
      alu(32'h60c, 5'd13, 5'd5, 5'd6));
    step();
    chk("ar_pre_v", exv(), 3);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_v", exv(), 0);
    chk("ar_inst_a", 32'(EX_inst_a == '0), 1);
    chk("ar_inst_b", 32'(EX_inst_b == '0), 1);
    chk("ar_a1", EX_rf_rdata_a1, 0);
    chk("ar_b2", EX_rf_rdata_b2, 0);
    chk("ar_ready", 32'(in_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("ar_empty_v", exv(), 0);

    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Dual-issue front end of the execute pipeline. Buffers decoded instructions in a circular queue and selects up to two per cycle into slots A and B. Resolves intra-bundle and load-use hazards, reads the register file with write-back bypass, and registers the EX-stage operand and control bundle consumed by `ex_mem_wb`. Honours the `EX_br` flush and the `stall_dcache` hold from that stage.

## Interface

- `DEPTH`, default 8: queue entries; power of two, ≥4.
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  2  decode push; `2'b01` pushes `in_inst0` only, `2'b11` pushes both. `2'b10` is illegal.
- `in_inst0`, `in_inst1`  in  `decoded_inst_t`  decoded instructions; `inst0` is older.
- `in_ready`  out  1  ≥2 free entries, computed from current occupancy before this cycle's pop.
- `rf_raddr_a1/a2/b1/b2`  out  5 each  combinational RF read addresses, taken from the selected head entries.
- `rf_rdata_a1/a2/b1/b2`  in  32 each  combinational RF read data.
- `WB_rf_we_a/b`  in  1  WB write enables, for bypass.
- `WB_rf_waddr_a/b`  in  5  WB write addresses, for bypass.
- `WB_rf_wdata_a/b`  in  32  WB write data, for bypass.
- `EX_br`  in  1  mispredict flush from EX.
- `stall_dcache`  in  1  global hold.
- `EX_valid_a/b`  out  1  slot occupied. An invalid slot drives an all-zero bundle, which means `rf_we=0` and `mem_we=0`.
- `EX_inst_a/b`  out  `decoded_inst_t`  registered bundle, all fields.
- `EX_rf_rdata_a1/a2/b1/b2`  out  32 each  registered operands.

## Operation

- **Queue:** head/tail pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits. Push and pop in the same cycle are legal; pop is applied first.
- **Slot rules:**
  - The oldest entry H0 always goes to slot A, except memory ops, which always use slot B.
  - If H0 is a memory op, it issues alone in slot B and slot A is a bubble.
  - The second entry H1 issues in slot B with H0 only if all of the following hold:
    - both entries are valid;
    - H0 is not a memory op;
    - H0 is not a branch (`br_type != 0`);
    - H1 reads no register that H0 writes, ignoring `r0`.
  - Otherwise H0 issues alone in slot A and slot B is a bubble.
- **Load-use tracking:** shadow registers `ex_ld` and `mem_ld` each hold a valid bit plus rd. They track the loads currently in EX and MEM.
  - Any candidate whose source matches a valid shadow rd (nonzero) blocks.
  - If H0 blocks, nothing issues and an all-bubble bundle is registered.
  - If only H1 blocks, H0 issues alone.
- **Bypass:** each operand takes WB data when the matching `WB_rf_we` is set, `WB_rf_waddr` equals the read address, and the read address is not `r0`. Slot B's write port has priority over slot A's. Otherwise the operand takes `rf_rdata`.
- **Priority:** flush > stall > issue.
  - Flush (`EX_br=1`): empty the queue, clear the EX outputs and `ex_ld`, and set `mem_ld <= ex_ld`. Same-cycle pushes are dropped.
  - Stall: all state is held and pushes are refused. `in_ready` is forced to 0 during stall.

## Timing

- All outputs are registered except `in_ready` and `rf_raddr_*`.
- Reset values:
  - queue empty;
  - `in_ready=1`;
  - `EX_valid_*=0`;
  - `EX_inst_*` all zero;
  - `EX_rf_rdata_*=0`;
  - both shadows invalid.
- Latency: an instruction pushed at edge N reaches the head at N+1 and appears on the EX outputs after edge N+1 at the earliest.
- A load issued at edge N blocks dependants at edges N+1 and N+2. The dependant issues at N+3, when the load is in WB and bypass supplies its data.
- Full queue (count ≥ `DEPTH-1`): `in_ready=0`. Pushes while `in_ready=0` are a protocol violation, flagged by an assertion.
- Empty queue: bubbles issue and `EX_valid_*=0`.
- Reset asserted mid-operation returns every output to its reset value asynchronously.

## Structure

- `issue_pkg` holds:
  - `decoded_inst_t` with fields `pc`, `imm`, `rf_raddr1/2`, `rf_re1/2`, `alu_src_sel1/2[2:0]`, `alu_op[11:0]`, `br_type[3:0]`, `br_pd`, `rf_we`, `rf_waddr`, `mem_we`, `mem_type[2:0]`, `is_load`, `wb_mux_select[5:0]`;
  - `is_mem()` and `reads_reg()` helper functions;
  - the constant `WB_SEL_LOAD=6'b000010`.
- Sub-module `issue_fifo`: 2-push/2-pop circular buffer that exposes H0/H1 and their valid bits. Hazard logic, bypass and EX registers stay in `issue_queue`.

## Test plan

1. **Independent ALU pair:** push `add r1,r2,r3` and `add r4,r5,r6` with the RF returning 10/20/30/40. After 2 edges, `EX_valid=2'b11` and operands are 10/20/30/40.
2. **RAW in pair:** `add r1,..` then `sub r7,r1,r2`. Cycle 1 issues A only; cycle 2 issues `sub` in slot A.
3. **Load-use:** `ld.w r5` then `add r6,r5,r5`. The load issues in slot B with A a bubble. Two bubble cycles follow. The `add` operands equal the WB data `0xDEADBEEF` via bypass.
4. **Flush:** queue holds 5 entries and `EX_br=1` with a simultaneous push. The next cycle shows count 0, `EX_valid=0` and `in_ready=1`.
5. **Stall and wrap:** hold `stall_dcache=1` for 3 cycles. The EX outputs stay unchanged and `in_ready=0`. Then stream 20 pushes and verify in-order issue across pointer wrap with `DEPTH=8`.
6. **Reset:** assert `rstn=0` mid-stream. All outputs go to their reset values without waiting for a clock edge.
